// File: rtl/fir_pkg.sv
// Shared constants and helpers for the FIR multiply-accumulate datapath.
// Default widths, accumulator limits and a sign-extension function.
package fir_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W = 39;

  localparam logic signed [DEF_ACC_W-1:0] ACC_MAX =
    {1'b0, {(DEF_ACC_W-1){1'b1}}};
  localparam logic signed [DEF_ACC_W-1:0] ACC_MIN =
    {1'b1, {(DEF_ACC_W-1){1'b0}}};

  function automatic logic [63:0] acc_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] acc_min(input int w);
    return ~acc_max(w);
  endfunction

  // Sign-extend the low w bits of v to 64 bits.
  function automatic logic [63:0] sext(
    input logic [63:0] v,
    input int w
  );
    logic signed [63:0] t;
    t = $signed(v << (64 - w));
    return t >>> (64 - w);
  endfunction

endpackage

// File: rtl/fir_sat_add.sv
// Signed accumulator adder with overflow flag.
// Optionally clamps to the signed range instead of wrapping.
module fir_sat_add
  import fir_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter bit SATURATE = 1'b0
) (
  input  logic signed [ACC_W-1:0] a,
  input  logic signed [ACC_W-1:0] b,
  output logic signed [ACC_W-1:0] sum,
  output logic                    ovf
);

  localparam logic [ACC_W-1:0] MAX = ACC_W'(acc_max(ACC_W));
  localparam logic [ACC_W-1:0] MIN = ACC_W'(acc_min(ACC_W));

  logic signed [ACC_W-1:0] raw;

  assign raw = a + b;
  assign ovf = (a[ACC_W-1] == b[ACC_W-1])
            && (raw[ACC_W-1] != a[ACC_W-1]);

  always_comb begin
    sum = raw;
    if (SATURATE && ovf) begin
      sum = a[ACC_W-1] ? MIN : MAX;
    end
  end

endmodule

// File: rtl/fir_mac_pipe.sv
// Two-stage signed MAC: S1 registers the product, S2 accumulates a frame.
// One result per frame with valid/ready backpressure and sticky overflow.
module fir_mac_pipe
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter bit SATURATE = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_x,
  input  logic signed [DATA_W-1:0] in_b,
  input  logic                     in_first,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_sum,
  output logic                     out_ovf
);

  localparam int PW = 2 * DATA_W;

  if (ACC_W < PW || ACC_W > 64) begin : g_width_chk
    $error("fir_mac_pipe: ACC_W must lie in [2*DATA_W, 64]");
  end

  logic                    s1_valid;
  logic                    s1_first;
  logic                    s1_last;
  logic signed [PW-1:0]    s1_prod;
  logic signed [ACC_W-1:0] acc;
  logic                    ovf_frame;
  logic signed [ACC_W-1:0] operand;
  logic signed [ACC_W-1:0] addend;
  logic signed [ACC_W-1:0] sum;
  logic                    step_ovf;
  logic                    ovf_next;
  logic                    stall;
  logic                    accept;
  logic                    s2_go;

  // Only a completed frame can collide with a held result.
  assign stall    = out_valid && !out_ready && s1_valid && s1_last;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;
  assign s2_go    = s1_valid && !stall;

  assign operand = ACC_W'(sext(64'($unsigned(s1_prod)), PW));
  assign addend  = s1_first ? '0 : acc;
  assign ovf_next = (s1_first ? 1'b0 : ovf_frame) | step_ovf;

  fir_sat_add #(
    .ACC_W    (ACC_W),
    .SATURATE (SATURATE)
  ) u_add (
    .a   (addend),
    .b   (operand),
    .sum (sum),
    .ovf (step_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_first <= in_first;
        s1_last  <= in_last;
        s1_prod  <= in_x * in_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      ovf_frame <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (s2_go) begin
        if (s1_last) begin
          out_sum   <= sum;
          out_ovf   <= ovf_next;
          out_valid <= 1'b1;
          acc       <= '0;
          ovf_frame <= 1'b0;
        end else begin
          acc       <= sum;
          ovf_frame <= ovf_next;
        end
      end
    end
  end

endmodule
